// File: rtl/proc_pkg.sv
// Shared processor definitions: sequencer state encoding and default widths
// reused by the instruction ROM, decode and the program counter sequencer.
package proc_pkg;

    localparam int unsigned PC_W  = 10;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Generic saturating up-counter with synchronous clear (priority) and enable.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Clear wins over enable; counting stops once every bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and IDLE/RUN/DONE sequencer feeding the instruction ROM.
// A req pulse starts (or restarts) the program at address 0; halt, stall and
// branch requests from decode steer the pc; stepping past LAST_PC ends the run.
module pc_sequencer #(
    parameter int unsigned PC_W    = proc_pkg::PC_W,
    parameter int unsigned LAST_PC = 1023,
    parameter int unsigned CNT_W   = proc_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             halt,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             stall,
    output logic [PC_W-1:0]  pc,
    output logic             run,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
);

    import proc_pkg::*;

    localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(LAST_PC);

    seq_state_t       r_state;
    logic [PC_W-1:0]  r_pc;
    logic             r_run;
    logic             r_done;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic [CNT_W-1:0] w_count;

    // A sampled req restarts from any state, so it always zeroes the count.
    assign w_cnt_clr = req;
    assign w_cnt_en  = (r_state == S_RUN);

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_count)
    );

    // Sequencer FSM with registered run/done and pc; priority in RUN is
    // req > halt > stall > branch > sequential step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_run   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_state <= S_RUN;
                        r_pc    <= '0;
                        r_run   <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (req) begin
                        r_pc <= '0;
                    end else if (halt) begin
                        r_state <= S_DONE;
                        r_run   <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (stall) begin
                        r_pc <= r_pc;
                    end else if (branch_taken) begin
                        r_pc <= branch_target;
                    end else if (r_pc == LAST_ADDR) begin
                        r_state <= S_DONE;
                        r_run   <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_pc <= r_pc + 1'b1;
                    end
                end
                S_DONE: begin
                    if (req) begin
                        r_state <= S_RUN;
                        r_pc    <= '0;
                        r_run   <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pc    <= '0;
                    r_run   <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign run         = r_run;
    assign done        = r_done;
    assign cycle_count = w_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a full-size instance and a small one
// (LAST_PC=5, CNT_W=4) share stimulus and are compared against a
// behavioural model every cycle, plus directed spot checks.
module tb_pc_sequencer;

    logic       clk;
    logic       reset;
    logic       req;
    logic       halt;
    logic       branch_taken;
    logic [9:0] branch_target;
    logic       stall;

    logic [9:0]  pc_a;
    logic        run_a;
    logic        done_a;
    logic [15:0] cnt_a;

    logic [9:0]  pc_b;
    logic        run_b;
    logic        done_b;
    logic [3:0]  cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per instance: 0 = full size, 1 = small
    int m_pc  [2];
    int m_cnt [2];
    bit m_run [2];
    bit m_done[2];
    int lastpc[2] = '{1023, 5};
    int cmax  [2] = '{65535, 15};

    pc_sequencer #(.PC_W(10), .LAST_PC(1023), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .req(req), .halt(halt),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
        .pc(pc_a), .run(run_a), .done(done_a), .cycle_count(cnt_a)
    );

    pc_sequencer #(.PC_W(10), .LAST_PC(5), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .req(req), .halt(halt),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
        .pc(pc_b), .run(run_b), .done(done_b), .cycle_count(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_cnt[k] = 0; m_run[k] = 1'b0; m_done[k] = 1'b0;
        end
    endfunction

    function automatic void model_step(input bit rq, input bit h, input bit b,
                                       input int t, input bit s);
        for (int k = 0; k < 2; k++) begin
            if (rq) begin
                m_run[k] = 1'b1; m_done[k] = 1'b0; m_pc[k] = 0; m_cnt[k] = 0;
            end else if (m_run[k]) begin
                if (m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
                if (h) begin
                    m_run[k] = 1'b0; m_done[k] = 1'b1;
                end else if (s) begin
                    m_pc[k] = m_pc[k];
                end else if (b) begin
                    m_pc[k] = t;
                end else if (m_pc[k] == lastpc[k]) begin
                    m_run[k] = 1'b0; m_done[k] = 1'b1;
                end else begin
                    m_pc[k] = (m_pc[k] + 1) % 1024;
                end
            end
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_pc_a"},   32'(pc_a),   32'(m_pc[0]));
        check({tag, "_run_a"},  32'(run_a),  32'(m_run[0]));
        check({tag, "_done_a"}, 32'(done_a), 32'(m_done[0]));
        check({tag, "_cnt_a"},  32'(cnt_a),  32'(m_cnt[0]));
        check({tag, "_pc_b"},   32'(pc_b),   32'(m_pc[1]));
        check({tag, "_run_b"},  32'(run_b),  32'(m_run[1]));
        check({tag, "_done_b"}, 32'(done_b), 32'(m_done[1]));
        check({tag, "_cnt_b"},  32'(cnt_b),  32'(m_cnt[1]));
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model on the
    // rising edge, compare on the next falling edge.
    task automatic step(input string tag, input bit rq, input bit h, input bit b,
                        input int t, input bit s);
        req = rq; halt = h; branch_taken = b; branch_target = 10'(t); stall = s;
        @(posedge clk);
        model_step(rq, h, b, t, s);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic nop(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    // Pull reset low between edges and confirm outputs clear before the next edge.
    task automatic async_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check({tag, "_pc"},   32'(pc_a),   32'd0);
        check({tag, "_run"},  32'(run_a),  32'd0);
        check({tag, "_done"}, 32'(done_a), 32'd0);
        check({tag, "_cnt"},  32'(cnt_a),  32'd0);
        compare_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int t;
        bit rq, h, b, s;
        reset = 1'b0; req = 1'b0; halt = 1'b0; branch_taken = 1'b0;
        branch_target = '0; stall = 1'b0;
        model_reset();
        #1;
        check("rst_pc",   32'(pc_a),   32'd0);
        check("rst_run",  32'(run_a),  32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_cnt",  32'(cnt_a),  32'd0);
        @(negedge clk);
        reset = 1'b1;
        nop("idle");

        // Basic run: pc 0,1,2,3 then halt
        step("t1_req", 1, 0, 0, 0, 0);
        check("t1_pc0", 32'(pc_a), 32'd0);
        check("t1_run0", 32'(run_a), 32'd1);
        nop("t1"); nop("t1"); nop("t1");
        check("t1_pc3", 32'(pc_a), 32'd3);
        step("t1_halt", 0, 1, 0, 0, 0);
        check("t1_done", 32'(done_a), 32'd1);
        check("t1_cnt", 32'(cnt_a), 32'd4);
        check("t1_pchold", 32'(pc_a), 32'd3);
        nop("t1_hold");
        check("t1_pchold2", 32'(pc_a), 32'd3);

        // Branch to 100 at pc=2, halt at 101
        step("t2_req", 1, 0, 0, 0, 0);
        check("t2_done_drop", 32'(done_a), 32'd0);
        nop("t2"); nop("t2");
        step("t2_br", 0, 0, 1, 100, 0);
        check("t2_pc100", 32'(pc_a), 32'd100);
        nop("t2");
        check("t2_pc101", 32'(pc_a), 32'd101);
        step("t2_halt", 0, 1, 0, 0, 0);
        check("t2_cnt", 32'(cnt_a), 32'd5);

        // Stall two cycles at pc=1
        step("t3_req", 1, 0, 0, 0, 0);
        nop("t3");
        step("t3_st", 0, 0, 0, 0, 1);
        step("t3_st", 0, 0, 0, 0, 1);
        check("t3_pc_stalled", 32'(pc_a), 32'd1);
        nop("t3");
        step("t3_halt", 0, 1, 0, 0, 0);
        check("t3_cnt", 32'(cnt_a), 32'd5);
        check("t3_pc", 32'(pc_a), 32'd2);

        // Run off end on the small instance
        step("t4_req", 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) nop("t4");
        check("t4_pc5", 32'(pc_b), 32'd5);
        check("t4_run5", 32'(run_b), 32'd1);
        nop("t4_end");
        check("t4_done", 32'(done_b), 32'd1);
        check("t4_nowrap", 32'(pc_b), 32'd5);
        // Branch onto LAST_PC is legal; completion only on the next step
        step("t4b_req", 1, 0, 0, 0, 0);
        step("t4b_br", 0, 0, 1, 5, 0);
        check("t4b_run", 32'(run_b), 32'd1);
        nop("t4b_end");
        check("t4b_done", 32'(done_b), 32'd1);
        // halt + branch at pc=1
        step("t4c_req", 1, 0, 0, 0, 0);
        nop("t4c");
        step("t4c_hb", 0, 1, 1, 9, 0);
        check("t4c_pc", 32'(pc_a), 32'd1);
        check("t4c_done", 32'(done_a), 32'd1);

        // Restart mid-run at pc=7, then restart from DONE
        step("t5_req", 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) nop("t5");
        check("t5_pc7", 32'(pc_a), 32'd7);
        step("t5_rst", 1, 0, 0, 0, 0);
        check("t5_pc0", 32'(pc_a), 32'd0);
        check("t5_cnt0", 32'(cnt_a), 32'd0);
        step("t5_halt", 0, 1, 0, 0, 0);
        step("t5_done_req", 1, 0, 0, 0, 0);
        check("t5_done0", 32'(done_a), 32'd0);
        check("t5_run1", 32'(run_a), 32'd1);
        // Held req keeps pc at 0
        step("t5_held", 1, 0, 0, 0, 0);
        step("t5_held", 1, 0, 0, 0, 0);
        check("t5_held_pc", 32'(pc_a), 32'd0);

        // Asynchronous reset mid-run
        nop("t6"); nop("t6");
        async_reset("t6_arst");

        // Saturation on the small instance
        step("t7_req", 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step("t7", 0, 0, 0, 0, 1);
        check("t7_sat", 32'(cnt_b), 32'd15);
        check("t7_full", 32'(cnt_a), 32'd20);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rq = ($urandom_range(0, 49) == 0);
            h  = ($urandom_range(0, 29) == 0);
            s  = ($urandom_range(0, 6) == 0);
            b  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) == 0) t = $urandom_range(1016, 1023);
            else if ($urandom_range(0, 1) == 0) t = $urandom_range(0, 6);
            else t = $urandom_range(0, 1023);
            if ($urandom_range(0, 399) == 0) begin
                async_reset("rnd_arst");
            end else begin
                step("rnd", rq, h, b, t, s);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program counter and run/done sequencer that sits directly upstream of instruction ROM, decode and register file inside top_level.
- Turns the single-cycle req pulse into a running program and drives the instruction address every cycle.
- Applies branch redirects and stalls from decode, and raises done once the program halts or runs off the end of the ROM.
- Also keeps a saturating count of executed cycles for bench-side performance checks.

Parameters:
- PC_W, 10, width of the program counter in bits (ROM depth 2^PC_W).
- LAST_PC, 1023, highest valid instruction address; a sequential step from it ends the program.
- CNT_W, 16, width of the cycle counter.

Ports:
- clk  in  1  system clock, all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- req  in  1  start request; sampled high for one or more cycles.
- halt  in  1  decode reports that the instruction at pc is a halt.
- branch_taken  in  1  decode reports a taken branch or jump at pc.
- branch_target  in  PC_W  absolute target address, valid when branch_taken=1.
- stall  in  1  hold pc this cycle (multi-cycle instruction).
- pc  out  PC_W  current instruction address to the ROM.
- run  out  1  high while instructions execute; downstream gates register-file and memory writes with it.
- done  out  1  program finished; level signal, held until the next req.
- cycle_count  out  CNT_W  number of RUN cycles since the last start, saturating.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, pc=0, run=0, done=0, cycle_count=0. All outputs take these values immediately, independent of clk.
- Release of reset is synchronous to clk. The rest of top_level handles release synchronisation.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - run=0, done=0.
  - req=1 -> RUN on the next edge, with pc=0 and cycle_count=0.
- RUN:
  - run=1. cycle_count increments every RUN cycle, including stalled cycles, and saturates at 2^CNT_W-1.
  - Priority per edge: req > halt > stall > branch_taken > sequential.
  - req=1: restart. pc<=0, cycle_count<=0, stay in RUN.
  - halt=1: -> DONE. pc holds. The halt instruction itself performs no writes.
  - stall=1: pc holds, stay in RUN.
  - branch_taken=1: pc<=branch_target.
  - Otherwise, if pc==LAST_PC: -> DONE and pc holds. This is the run-off-end case; no wrap to 0.
  - Otherwise: pc<=pc+1.
- DONE:
  - run=0, done=1. pc and cycle_count hold their final values.
  - req=1 -> RUN with pc=0, cycle_count=0. done drops on that same edge.
- Latency: the first instruction address (0) appears with run=1 one cycle after req is sampled. done rises one cycle after halt is sampled.
- Simultaneous events:
  - halt with branch_taken: halt wins.
  - halt with stall: halt wins.
  - branch_taken to LAST_PC is legal; completion is decided only when stepping sequentially from LAST_PC.
- Inputs halt, branch_taken and stall are ignored outside RUN.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs at their reset values.
- Held req: each sampled high cycle restarts, so pc stays 0 until req drops.

Decomposition:
- Shared package proc_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default constants PC_W and CNT_W, reused by instruction ROM and decode.
- Natural sub-module: sat_counter, a generic CNT_W saturating counter with clear and enable, used for cycle_count.
- The FSM and pc register stay in pc_sequencer.

Test Plan:
- Reset then req pulse at 10ns; halt driven when pc==3 -> pc sequence 0,1,2,3; run=1 for 4 cycles; done=1 one cycle after halt; cycle_count=4; pc holds at 3.
- Branch: branch_taken=1 with branch_target=10'd100 at pc=2, halt at pc=101 -> pc sequence 0,1,2,100,101; done=1; cycle_count=5.
- Stall: stall=1 for 2 cycles at pc=1, halt at pc=2 -> pc sequence 0,1,1,1,2; cycle_count=5.
- Run off end with LAST_PC=5 and no halt -> pc 0..5, then done=1 with pc=5 and no wrap to 0. Simultaneous halt+branch_taken at pc=1 -> DONE with pc=1, branch ignored.
- Restart: req mid-RUN at pc=7 -> pc=0 next cycle, cycle_count=0. req in DONE -> done=0 and pc=0 on the same edge.
- Reset pulled low asynchronously between clock edges mid-RUN -> pc=0, run=0, done=0, cycle_count=0 before the next edge.
- Saturation with CNT_W=4: 20 RUN cycles -> cycle_count=15.
